mem_stage_unit: RTL and testbench
=================================

# mem_stage_unit

Memory-stage consumer of the 109-bit EX/MEM pipeline bundle. Decodes the bundle, performs byte/half/word loads and stores over a request/acknowledge data-memory port, stalls upstream pipeline registers while an access is outstanding, and owns the 39-bit MEM/WB register it feeds into writeback.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width. Only 32 is supported.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- areset_n  in  1  asynchronous active-low reset.
- exmem_data  in  109  EX/MEM bundle, layout below.
- dmem_req  out  1  access request, held until acknowledged.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {alu_result[31:2],2'b00}.
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access complete; for loads, dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  load data.
- stall  out  1  deasserts write_enable of PC/IF-ID/ID-EX/EX-MEM registers.
- memwb_data  out  39  {valid[38], reg_write[37], rd[36:32], wb_value[31:0]}.
- misalign_err  out  1  one-cycle registered error pulse.

EX/MEM layout: pc_plus4[108:77], alu_result[76:45], store_data[44:13], rd[12:8], mem_read[7], mem_write[6], reg_write[5], mem_to_reg[4], size[3:2] (00 byte, 01 half, 10 word, 11 reserved), load_signed[1], valid[0].

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, valid=1, mem_read or mem_write set, aligned: stall=1, go to ACCESS; memwb_data.valid=0 at the next edge (bubble).
- IDLE, no memory op: MEM/WB loads {valid, reg_write, rd, alu_result} at the next edge.
- ACCESS: dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata are stable until ack. On dmem_ack: stall=0 in that same cycle; at the edge, MEM/WB loads the result and the FSM returns to IDLE. Without ack: stall=1, MEM/WB valid=0.
- Load wb_value: lane selected by alu_result[1:0] (little-endian). Zero- or sign-extended per load_signed. When mem_to_reg=0, alu_result is used instead.
- Store: byte uses lane replication of store_data[7:0] with be=0001<<addr[1:0]. Half uses replication of [15:0] with be=0011 or 1100. Word uses be=1111. A store writes memwb with reg_write forced to 0.
- Misaligned or illegal access: half with addr[0]=1, word with addr[1:0]≠0, or size=11 on a memory op. No request is issued and no stall occurs. At the next edge, MEM/WB gets valid=1, reg_write=0, and misalign_err=1 for one cycle.
- mem_read and mem_write both set: treated as a store.
- valid=0 bundle: MEM/WB valid=0, no access.

## Timing
- Reset values: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, stall=0, memwb_data=0, misalign_err=0. Assertion clears all of these immediately (asynchronously), including when asserted mid-ACCESS. A pending access is abandoned.
- Non-memory op: 1-cycle latency to memwb_data.
- Memory op: minimum 2 cycles (decide, then ACCESS with ack in the same cycle). Each extra wait cycle adds 1.
- stall is combinational from state, exmem_data and dmem_ack. The ack→stall path must close within one cycle.
- dmem_ack in IDLE is ignored.

## Structure
- Package mem_stage_pkg holds:
  - EX/MEM and MEM/WB field offset constants.
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum {IDLE, ACCESS}.
- Sub-module load_align (combinational): rdata, addr[1:0], size, load_signed → 32-bit extended value.
- The MEM/WB register and FSM live in the top module.

## Test plan
- Reset: hold areset_n=0 with garbage on all inputs → every output is 0. Release → state IDLE.
- ALU pass-through: valid=1, reg_write=1, rd=5, alu_result=0x1234 → next edge memwb_data={1,1,5,0x00001234}, stall never asserted.
- Signed byte load: addr=0x103, rdata=0x80FFFFFF, ack after 3 wait cycles. Expected:
  - stall high for 4 cycles;
  - dmem_addr=0x100;
  - wb_value=0xFFFFFF80.
- Half store: addr=0x22, store_data=0xABCD, immediate ack. Expected:
  - dmem_we=1, be=1100, wdata=0xABCDABCD;
  - memwb reg_write=0;
  - latency 2 cycles.
- Misaligned word load: addr=0x41 → no dmem_req, misalign_err pulses 1 cycle, memwb valid=1, reg_write=0.
- Reset mid-ACCESS: assert areset_n=0 while dmem_req=1 → dmem_req and stall drop immediately. Stray ack after release → ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Field offsets, size encodings and FSM state type shared by
//               the memory-stage unit and its load alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    // EX/MEM bundle layout
    localparam int c_EXMEM_W        = 109;
    localparam int c_EXMEM_PC_LSB   = 77;
    localparam int c_EXMEM_ALU_LSB  = 45;
    localparam int c_EXMEM_SD_LSB   = 13;
    localparam int c_EXMEM_RD_LSB   = 8;
    localparam int c_EXMEM_MRD_BIT  = 7;
    localparam int c_EXMEM_MWR_BIT  = 6;
    localparam int c_EXMEM_RW_BIT   = 5;
    localparam int c_EXMEM_M2R_BIT  = 4;
    localparam int c_EXMEM_SZ_LSB   = 2;
    localparam int c_EXMEM_SGN_BIT  = 1;
    localparam int c_EXMEM_VLD_BIT  = 0;

    // MEM/WB register layout
    localparam int c_MEMWB_W        = 39;
    localparam int c_MEMWB_VLD_BIT  = 38;
    localparam int c_MEMWB_RW_BIT   = 37;
    localparam int c_MEMWB_RD_LSB   = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Reserved size counts as an illegal access, like any misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_unit_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half lane of a load word and
//               zero- or sign-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_signed,
    output logic [31:0] value
);

    logic [31:0] w_shifted;
    logic [15:0] w_half;

    assign w_shifted = rdata >> {addr_lo, 3'b000};
    assign w_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (size)
            SZ_BYTE: value = {{24{load_signed & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: value = {{16{load_signed & w_half[15]}}, w_half};
            default: value = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_unit.sv
// ============================================================================
// Module      : mem_stage_unit
// Description : Memory pipeline stage: decodes EX/MEM, runs req/ack data
//               memory accesses, stalls upstream and owns the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic [c_EXMEM_W-1:0]   exmem_data,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic [DATA_W-1:0]      dmem_wdata,
    output logic [DATA_W/8-1:0]    dmem_be,
    input  logic                   dmem_ack,
    input  logic [DATA_W-1:0]      dmem_rdata,
    output logic                   stall,
    output logic [c_MEMWB_W-1:0]   memwb_data,
    output logic                   misalign_err
);

    logic [31:0] w_alu;
    logic [31:0] w_sd;
    logic [4:0]  w_rd;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic [1:0]  w_size;
    logic        w_load_signed;
    logic        w_valid;
    logic        w_unused_pc;

    assign w_alu         = exmem_data[c_EXMEM_ALU_LSB +: 32];
    assign w_sd          = exmem_data[c_EXMEM_SD_LSB +: 32];
    assign w_rd          = exmem_data[c_EXMEM_RD_LSB +: 5];
    assign w_mem_read    = exmem_data[c_EXMEM_MRD_BIT];
    assign w_mem_write   = exmem_data[c_EXMEM_MWR_BIT];
    assign w_reg_write   = exmem_data[c_EXMEM_RW_BIT];
    assign w_mem_to_reg  = exmem_data[c_EXMEM_M2R_BIT];
    assign w_size        = exmem_data[c_EXMEM_SZ_LSB +: 2];
    assign w_load_signed = exmem_data[c_EXMEM_SGN_BIT];
    assign w_valid       = exmem_data[c_EXMEM_VLD_BIT];
    assign w_unused_pc   = ^exmem_data[c_EXMEM_PC_LSB +: 32];

    logic w_mem_op;
    logic w_misalign;
    logic w_access_ok;

    assign w_mem_op    = w_valid & (w_mem_read | w_mem_write);
    assign w_misalign  = is_misaligned(w_size, w_alu[1:0]);
    assign w_access_ok = w_mem_op & ~w_misalign;

    // Store lane replication; mem_write wins over mem_read when both are set.
    logic [31:0] w_st_data;
    logic [3:0]  w_st_be;

    always_comb begin
        w_st_data = w_sd;
        w_st_be   = 4'b1111;
        case (w_size)
            SZ_BYTE: begin
                w_st_data = {4{w_sd[7:0]}};
                w_st_be   = 4'b0001 << w_alu[1:0];
            end
            SZ_HALF: begin
                w_st_data = {2{w_sd[15:0]}};
                w_st_be   = w_alu[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_data = w_sd;
                w_st_be   = 4'b1111;
            end
        endcase
    end

    logic [31:0] w_load_val;
    logic [31:0] w_wb_value;

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (w_alu[1:0]),
        .size        (w_size),
        .load_signed (w_load_signed),
        .value       (w_load_val)
    );

    assign w_wb_value = (w_mem_to_reg & ~w_mem_write) ? w_load_val : w_alu;

    state_t w_next_state;
    state_t r_state;
    logic   w_stall;

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access_ok) begin
                    w_stall      = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    w_next_state = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Gated by reset so garbage on exmem_data cannot stall the pipe in reset.
    assign stall = areset_n & w_stall;

    logic                 r_req;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W/8-1:0]  r_be;
    logic [c_MEMWB_W-1:0] r_memwb;
    logic                 r_misalign_err;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state        <= IDLE;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_be           <= '0;
            r_memwb        <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_misalign_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access_ok) begin
                        r_req   <= 1'b1;
                        r_we    <= w_mem_write;
                        r_addr  <= {w_alu[ADDR_W-1:2], 2'b00};
                        r_wdata <= w_st_data;
                        r_be    <= w_st_be;
                        r_memwb <= '0;
                    end else if (w_mem_op) begin
                        r_memwb        <= {1'b1, 1'b0, w_rd, w_alu};
                        r_misalign_err <= 1'b1;
                    end else begin
                        r_memwb <= {w_valid, w_reg_write, w_rd, w_alu};
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_be    <= '0;
                        r_memwb <= {1'b1, w_reg_write & ~w_mem_write, w_rd, w_wb_value};
                    end else begin
                        r_memwb <= '0;
                    end
                end
                default: r_memwb <= '0;
            endcase
        end
    end

    assign dmem_req     = r_req;
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_wdata   = r_wdata;
    assign dmem_be      = r_be;
    assign memwb_data   = r_memwb;
    assign misalign_err = r_misalign_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
// ============================================================================
// Module      : tb_mem_stage_unit
// Description : Self-checking bench for mem_stage_unit: directed scenarios
//               followed by random bundles against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_unit;

    logic         clk = 1'b0;
    logic         areset_n = 1'b0;
    logic [108:0] exmem_data = '0;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_ack = 1'b0;
    logic [31:0]  dmem_rdata = '0;
    logic         stall;
    logic [38:0]  memwb_data;
    logic         misalign_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .exmem_data   (exmem_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .memwb_data   (memwb_data),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [108:0] mk(input logic [31:0] alu, input logic [31:0] sd,
                                        input logic [4:0] rd, input bit mr, input bit mw,
                                        input bit rw, input bit m2r, input logic [1:0] sz,
                                        input bit ls, input bit v);
        logic [31:0] pc;
        pc = $urandom;
        return {pc, alu, sd, rd, mr, mw, rw, m2r, sz, ls, v};
    endfunction

    // Lane extraction by arithmetic: shift, modulo lane width, then extend.
    function automatic logic [31:0] m_load(input logic [31:0] rdata, input int a,
                                           input int nb, input bit sgn);
        longint unsigned v;
        longint unsigned m;
        m = 64'd1 << (8 * nb);
        v = (64'(rdata) >> (8 * a)) % m;
        if (sgn && nb < 4 && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    task automatic run_op(input string tag, input logic [108:0] b, input int waits,
                          input logic [31:0] rdata);
        logic [31:0] alu, sd, exp_wd;
        logic [4:0]  rd;
        logic [3:0]  exp_be;
        bit          mr, mw, rw, m2r, ls, v, memop, bad;
        int          sz, a, nb, stalls;
        alu = b[76:45]; sd = b[44:13]; rd = b[12:8];
        mr = b[7]; mw = b[6]; rw = b[5]; m2r = b[4];
        sz = int'(b[3:2]); ls = b[1]; v = b[0];
        a  = int'(alu[1:0]);
        nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        memop = v && (mr || mw);
        bad   = memop && (sz == 3 || (a % nb) != 0);
        exp_be = (sz == 0) ? 4'(1 << a) : (sz == 1) ? 4'(3 << a) : 4'hF;
        exp_wd = (sz == 0) ? 32'(sd[7:0]) * 32'h0101_0101 :
                 (sz == 1) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;

        exmem_data = b;
        dmem_ack   = 1'($urandom % 2);
        dmem_rdata = $urandom;
        #1;
        if (!memop) begin
            check({tag, ".stall"}, 64'(stall), 64'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (v) check({tag, ".memwb"}, 64'(memwb_data), 64'({1'b1, rw, rd, alu}));
            else   check({tag, ".memwb_vld"}, 64'(memwb_data[38]), 64'd0);
            check({tag, ".req"}, 64'(dmem_req), 64'd0);
            check({tag, ".merr"}, 64'(misalign_err), 64'd0);
        end else if (bad) begin
            check({tag, ".stall"}, 64'(stall), 64'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            check({tag, ".req"}, 64'(dmem_req), 64'd0);
            check({tag, ".merr"}, 64'(misalign_err), 64'd1);
            check({tag, ".memwb_hi"}, 64'(memwb_data[38:32]), 64'({2'b10, rd}));
        end else begin
            stalls = stall ? 1 : 0;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            #1;
            check({tag, ".req"}, 64'(dmem_req), 64'd1);
            check({tag, ".we"}, 64'(dmem_we), 64'(mw));
            check({tag, ".addr"}, 64'(dmem_addr), 64'({alu[31:2], 2'b00}));
            check({tag, ".be"}, 64'(dmem_be), 64'(mw ? exp_be : dmem_be));
            if (mw) check({tag, ".wdata"}, 64'(dmem_wdata), 64'(exp_wd));
            check({tag, ".bubble"}, 64'(memwb_data[38]), 64'd0);
            for (int i = 0; i < waits; i++) begin
                dmem_rdata = $urandom;
                #1;
                if (stall) stalls++;
                @(posedge clk); #1;
                check({tag, ".req_hold"}, 64'(dmem_req), 64'd1);
                check({tag, ".wait_vld"}, 64'(memwb_data[38]), 64'd0);
            end
            dmem_rdata = rdata;
            dmem_ack   = 1'b1;
            #1;
            check({tag, ".ack_stall"}, 64'(stall), 64'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            check({tag, ".stall_cycles"}, 64'(stalls), 64'(waits + 1));
            check({tag, ".req_done"}, 64'(dmem_req), 64'd0);
            if (mw)
                check({tag, ".memwb_hi"}, 64'(memwb_data[38:32]), 64'({2'b10, rd}));
            else
                check({tag, ".memwb"}, 64'(memwb_data),
                      64'({1'b1, rw, rd, m2r ? m_load(rdata, a, nb, ls) : alu}));
        end
    endtask

    initial begin
        // Reset with garbage: a valid aligned load on exmem and ack high.
        exmem_data = mk($urandom & 32'hFFFF_FFFC, $urandom, 5'd3, 1, 0, 1, 1, 2'b10, 0, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req", 64'(dmem_req), 64'd0);
        check("rst.we", 64'(dmem_we), 64'd0);
        check("rst.addr", 64'(dmem_addr), 64'd0);
        check("rst.wdata", 64'(dmem_wdata), 64'd0);
        check("rst.be", 64'(dmem_be), 64'd0);
        check("rst.stall", 64'(stall), 64'd0);
        check("rst.memwb", 64'(memwb_data), 64'd0);
        check("rst.merr", 64'(misalign_err), 64'd0);
        exmem_data = '0;
        dmem_ack   = 1'b0;
        areset_n   = 1'b1;

        run_op("alu_pass", mk(32'h1234, 32'h0, 5'd5, 0, 0, 1, 0, 2'b10, 0, 1), 0, 0);
        run_op("lb_signed", mk(32'h103, 32'h0, 5'd7, 1, 0, 1, 1, 2'b00, 1, 1), 3, 32'h80FF_FFFF);
        run_op("sh_store", mk(32'h22, 32'hABCD, 5'd9, 0, 1, 1, 0, 2'b01, 0, 1), 0, 0);
        run_op("lw_misal", mk(32'h41, 32'h0, 5'd4, 1, 0, 1, 1, 2'b10, 0, 1), 0, 0);
        run_op("lhu", mk(32'h2, 32'h0, 5'd1, 1, 0, 1, 1, 2'b01, 0, 1), 1, 32'h9876_5432);
        run_op("rw_both", mk(32'h10, 32'hDEAD_BEEF, 5'd2, 1, 1, 1, 1, 2'b10, 0, 1), 2, 0);
        run_op("bubble_in", mk(32'h8, 32'h0, 5'd6, 1, 0, 1, 1, 2'b10, 0, 0), 0, 0);

        // Reset asserted mid-access, then a stray ack after release.
        exmem_data = mk(32'h200, 32'h0, 5'd8, 1, 0, 1, 1, 2'b10, 0, 1);
        dmem_ack   = 1'b0;
        @(posedge clk); #1;
        check("mid.req_before", 64'(dmem_req), 64'd1);
        #2;
        areset_n = 1'b0;
        #1;
        check("mid.req", 64'(dmem_req), 64'd0);
        check("mid.stall", 64'(stall), 64'd0);
        check("mid.addr", 64'(dmem_addr), 64'd0);
        @(posedge clk); #1;
        exmem_data = '0;
        areset_n   = 1'b1;
        dmem_ack   = 1'b1;
        @(posedge clk); #1;
        check("stray.req", 64'(dmem_req), 64'd0);
        check("stray.stall", 64'(stall), 64'd0);
        check("stray.vld", 64'(memwb_data[38]), 64'd0);
        dmem_ack = 1'b0;

        for (int k = 0; k < 150; k++) begin
            int op;
            op = int'($urandom % 4);
            run_op("rand",
                   mk($urandom, $urandom, 5'($urandom), op == 1 || op == 3, op >= 2,
                      1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                      ($urandom % 8) != 0),
                   int'($urandom % 4), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
